// File: rtl/ser_bus_xfer.sv
// rtl/ser_bus_xfer.sv - parametrised serial bus transfer engine ('165-style shift out / shift in)
//
// Purpose: owns a complete serial transaction. It pulses ser_shld low, then
// runs BITS ser_clk periods. Each lane shifts a tx bit out and captures one
// rx bit per period. The assembled word appears on rx_word with a one-cycle
// done pulse.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   start    - transfer request, accepted only while idle
//   tx_word  - word to send, lane i = bits [(i+1)*BITS-1 : i*BITS]
//   rx_word  - last received word, same lane mapping
//   busy     - high from the cycle after acceptance until the DONE cycle
//   done     - one-cycle pulse once rx_word has been updated
//   ser_shld - active-low load strobe to the external shifters
//   ser_clk  - serial shift clock
//   ser_out  - serial data out, one bit per lane
//   ser_in   - serial data in, one bit per lane
module ser_bus_xfer #(
    parameter int CHANNELS  = 2,
    parameter int BITS      = 8,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [CHANNELS*BITS-1:0] tx_word,
    output logic [CHANNELS*BITS-1:0] rx_word,
    output logic                     busy,
    output logic                     done,
    output logic                     ser_shld,
    output logic                     ser_clk,
    output logic [CHANNELS-1:0]      ser_out,
    input  logic [CHANNELS-1:0]      ser_in
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t                         state;
    logic [DIV_W-1:0]               div_cnt;
    logic [BIT_W-1:0]               bit_cnt;
    logic [CHANNELS-1:0][BITS-1:0]  tx_sr;
    logic [CHANNELS-1:0][BITS-1:0]  rx_sr;

    logic [CHANNELS-1:0][BITS-1:0]  tx_load;
    logic [CHANNELS-1:0][BITS-1:0]  tx_adv;
    logic [CHANNELS-1:0][BITS-1:0]  rx_cap;
    logic [CHANNELS-1:0]            first_bit;
    logic [CHANNELS-1:0]            next_bit;

    // Per-lane shift helpers. The bit on the line is always the end of tx_sr
    // nearest the shift direction, so the "next" bit comes from the advanced value.
    always_comb begin
        tx_load   = tx_word;
        tx_adv    = '0;
        rx_cap    = '0;
        first_bit = '0;
        next_bit  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (MSB_FIRST) begin
                tx_adv[i]    = tx_sr[i] << 1;
                first_bit[i] = tx_load[i][BITS-1];
                next_bit[i]  = tx_adv[i][BITS-1];
                rx_cap[i]    = (rx_sr[i] << 1) | BITS'(ser_in[i]);
            end else begin
                tx_adv[i]    = tx_sr[i] >> 1;
                first_bit[i] = tx_load[i][0];
                next_bit[i]  = tx_adv[i][0];
                rx_cap[i]    = (rx_sr[i] >> 1) | (BITS'(ser_in[i]) << (BITS - 1));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_word  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ser_shld <= 1'b1;
            ser_clk  <= 1'b0;
            ser_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tx_sr    <= tx_load;
                        rx_sr    <= '0;
                        ser_out  <= first_bit;
                        ser_shld <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        ser_shld <= 1'b1;
                        state    <= S_LOW;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_LOW: begin
                    // ser_in is captured on the same edge that raises ser_clk,
                    // so the external device still presents the pre-shift bit.
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ser_clk <= 1'b1;
                        rx_sr   <= rx_cap;
                        state   <= S_HIGH;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ser_clk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            // ser_out keeps the last bit; busy drops as DONE begins.
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            tx_sr   <= tx_adv;
                            ser_out <= next_bit;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            state   <= S_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    rx_word <= rx_sr;
                    done    <= 1'b1;
                    bit_cnt <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_bus_xfer.sv
// tb/tb_ser_bus_xfer.sv - self-checking bench for ser_bus_xfer
module tb_ser_bus_xfer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n;
    logic [2:0]            start_v, busy_v, done_v, shld_v, sclk_v;
    logic [2:0][15:0]      tx_v, rx_v;
    logic [2:0][1:0]       sout_v, sin_v;

    // Instance 0: DIV=1 MSB first, 1: DIV=3 MSB first, 2: DIV=1 LSB first
    int div_of [3] = '{1, 3, 1};
    bit msb_of [3] = '{1'b1, 1'b1, 1'b0};

    // External '165-style device per lane on instance 0
    logic            ext_mode = 1'b0;
    logic [1:0][7:0] ext_sr   = '0;
    logic [1:0][7:0] ext_pre  = '0;
    logic            ext_prev = 1'b0;

    always @(posedge clk) begin
        if (!shld_v[0]) ext_sr <= ext_pre;
        else if (sclk_v[0] && !ext_prev) begin
            ext_sr[0] <= {ext_sr[0][6:0], 1'b0};
            ext_sr[1] <= {ext_sr[1][6:0], 1'b0};
        end
        ext_prev <= sclk_v[0];
    end

    assign sin_v[0] = ext_mode ? {ext_sr[1][7], ext_sr[0][7]} : sout_v[0];
    assign sin_v[1] = sout_v[1];
    assign sin_v[2] = sout_v[2];

    ser_bus_xfer #(.CHANNELS(2), .BITS(8), .DIV(1), .MSB_FIRST(1'b1)) u_d0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .tx_word(tx_v[0]),
        .rx_word(rx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .ser_shld(shld_v[0]),
        .ser_clk(sclk_v[0]), .ser_out(sout_v[0]), .ser_in(sin_v[0]));

    ser_bus_xfer #(.CHANNELS(2), .BITS(8), .DIV(3), .MSB_FIRST(1'b1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .tx_word(tx_v[1]),
        .rx_word(rx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .ser_shld(shld_v[1]),
        .ser_clk(sclk_v[1]), .ser_out(sout_v[1]), .ser_in(sin_v[1]));

    ser_bus_xfer #(.CHANNELS(2), .BITS(8), .DIV(1), .MSB_FIRST(1'b0)) u_d2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .tx_word(tx_v[2]),
        .rx_word(rx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .ser_shld(shld_v[2]),
        .ser_clk(sclk_v[2]), .ser_out(sout_v[2]), .ser_in(sin_v[2]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transfer on instance k, measured from the outside.
    task automatic run_xfer(input int k, input logic [15:0] tx, input int restart_at,
                            input logic [15:0] exp_rx);
        int         lat, nclk, nshld, nbusy, ndone, hi_min, hi_max, hrun, bit_idx;
        int         exp_lat, d;
        logic       prev_clk;
        logic [15:0] cap, prev_rx;
        logic [1:0]  exp_first;

        d        = div_of[k];
        exp_lat  = d * (1 + 2 * 8) + 1;
        prev_rx  = rx_v[k];
        lat = -1; nclk = 0; nshld = 0; nbusy = 0; ndone = 0;
        hi_min = 1000; hi_max = 0; hrun = 0; bit_idx = 0;
        prev_clk = 1'b0; cap = '0;

        @(negedge clk);
        start_v[k] = 1'b1;
        tx_v[k]    = tx;
        @(negedge clk);
        start_v[k] = 1'b0;
        tx_v[k]    = 16'($urandom);

        exp_first[0] = msb_of[k] ? tx[7]  : tx[0];
        exp_first[1] = msb_of[k] ? tx[15] : tx[8];
        check("first_bit", 32'(sout_v[k]), 32'(exp_first));
        check("rx_hold", 32'(rx_v[k]), 32'(prev_rx));

        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == restart_at) begin
                start_v[k] = 1'b1;
                tx_v[k]    = 16'hffff;
            end else begin
                start_v[k] = 1'b0;
            end
            if (!shld_v[k]) nshld++;
            if (busy_v[k]) nbusy++;
            if (done_v[k]) begin
                ndone++;
                if (lat < 0) lat = cyc;
            end
            if (sclk_v[k]) hrun++;
            if (sclk_v[k] && !prev_clk) begin
                nclk++;
                if (bit_idx < 8) begin
                    for (int l = 0; l < 2; l++)
                        cap[l*8 + (msb_of[k] ? 7 - bit_idx : bit_idx)] = sout_v[k][l];
                end
                bit_idx++;
            end
            if (!sclk_v[k] && prev_clk) begin
                if (hrun < hi_min) hi_min = hrun;
                if (hrun > hi_max) hi_max = hrun;
                hrun = 0;
            end
            prev_clk = sclk_v[k];
            if (lat >= 0 && cyc >= lat + 3) break;
        end
        start_v[k] = 1'b0;

        check("latency", 32'(lat), 32'(exp_lat));
        check("ser_clk_edges", 32'(nclk), 32'd8);
        check("shld_low_cycles", 32'(nshld), 32'(d));
        check("busy_cycles", 32'(nbusy), 32'(d * 17));
        check("done_pulses", 32'(ndone), 32'd1);
        check("high_min", 32'(hi_min), 32'(d));
        check("high_max", 32'(hi_max), 32'(d));
        check("ser_out_order", 32'(cap), 32'(tx));
        check("rx_word", 32'(rx_v[k]), 32'(exp_rx));
        check("busy_after", 32'(busy_v[k]), 32'd0);
    endtask

    initial begin
        logic [15:0] tx, pre;
        int          k, ra, ndone_rst;

        reset_n = 1'b0;
        start_v = '0;
        tx_v    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_shld", 32'(shld_v[0]), 32'd1);
        check("rst_sclk", 32'(sclk_v[0]), 32'd0);
        check("rst_sout", 32'(sout_v[0]), 32'd0);
        check("rst_rx", 32'(rx_v[0]), 32'd0);
        reset_n = 1'b1;

        run_xfer(0, 16'haa55, -1, 16'haa55);
        run_xfer(1, 16'h1234, -1, 16'h1234);

        ext_pre  = {8'h5a, 8'hc3};
        ext_mode = 1'b1;
        run_xfer(0, 16'h0000, -1, 16'h5ac3);
        ext_mode = 1'b0;

        run_xfer(0, 16'h3c96, 5, 16'h3c96);
        run_xfer(0, 16'h7e81, 17, 16'h7e81);
        run_xfer(2, 16'h8001, -1, 16'h8001);

        // Reset in the middle of a transfer
        @(negedge clk);
        start_v[0] = 1'b1;
        tx_v[0]    = 16'hc0de;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        check("mid_rst_shld", 32'(shld_v[0]), 32'd1);
        check("mid_rst_sclk", 32'(sclk_v[0]), 32'd0);
        check("mid_rst_sout", 32'(sout_v[0]), 32'd0);
        check("mid_rst_rx", 32'(rx_v[0]), 32'd0);
        ndone_rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_v[0]) ndone_rst++;
            if (i == 2) reset_n = 1'b1;
        end
        check("mid_rst_no_done", 32'(ndone_rst), 32'd0);
        run_xfer(0, 16'h4d2b, -1, 16'h4d2b);

        // Randomized transfers against the reference rules
        for (int n = 0; n < 18; n++) begin
            k  = int'($urandom_range(0, 2));
            tx = 16'($urandom);
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, div_of[k] * 17)) : -1;
            if (k == 0 && $urandom_range(0, 1) == 1) begin
                pre      = 16'($urandom);
                ext_pre  = pre;
                ext_mode = 1'b1;
                run_xfer(k, tx, ra, pre);
                ext_mode = 1'b0;
            end else begin
                run_xfer(k, tx, ra, tx);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
